// File: rtl/hazard_ctrl_param.sv
// Operand/store forwarding selects plus load-use stall FSM; statistics counters built only with HAZ_STATS_EN.
// Latency: forwarding and stall/bubble are combinational (zero cycle); counters update on the next rising edge.
// Backpressure: stall holds PC and IF/ID for LOAD_LAT cycles per load-use hazard; flush overrides stall at once.
module hazard_ctrl_param #(
    parameter int REG_W    = 4,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_re,
    input  logic [NUM_SRC*REG_W-1:0] ex_src,
    input  logic [NUM_SRC-1:0]       ex_re,
    input  logic [REG_W-1:0]         ex_dst,
    input  logic                     ex_we,
    input  logic                     ex_is_load,
    input  logic [REG_W-1:0]         mem_dst,
    input  logic                     mem_we,
    input  logic                     mem_st,
    input  logic [REG_W-1:0]         mem_st_src,
    input  logic [REG_W-1:0]         wb_dst,
    input  logic                     wb_we,
    input  logic                     flush,
    output logic [2*NUM_SRC-1:0]     fwd_sel,
    output logic                     st_fwd,
    output logic                     stall,
    output logic                     bubble,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [CNT_W-1:0]         hazard_events
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [3:0] REM_INIT = 4'(LOAD_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic       src_hit;
    logic       hz;

    // MEM is checked first: it carries the youngest producer of the register.
    always_comb begin
        fwd_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ex_re[k] && mem_we && (ex_src[k*REG_W +: REG_W] == mem_dst)) begin
                fwd_sel[2*k +: 2] = 2'b01;
            end else if (ex_re[k] && wb_we && (ex_src[k*REG_W +: REG_W] == wb_dst)) begin
                fwd_sel[2*k +: 2] = 2'b10;
            end
        end
    end

    assign st_fwd = mem_st & wb_we & (mem_st_src == wb_dst);

    always_comb begin
        src_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_re[k] && (id_src[k*REG_W +: REG_W] == ex_dst)) begin
                src_hit = 1'b1;
            end
        end
    end

    assign hz = id_valid & ex_is_load & ex_we & src_hit & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // EX holds bubbles while in STALL, so hz is not evaluated there.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = hz;
                if (hz) begin
                    rem_d = REM_INIT;
                    if (REM_INIT != 4'd0) begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                stall = ~flush;
                if (flush || (rem_q == 4'd1)) begin
                    state_d = IDLE;
                    rem_d   = 4'd0;
                end else begin
                    rem_d = rem_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = 4'd0;
            end
        endcase
    end

    assign bubble = stall;

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] evt_cnt_q;
    logic             hz_evt;

    assign hz_evt = (state_q == IDLE) & hz;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            evt_cnt_q   <= '0;
        end else begin
            if (stall && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (hz_evt && !(&evt_cnt_q)) begin
                evt_cnt_q <= evt_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign hazard_events = evt_cnt_q;
`else
    assign stall_cycles  = '0;
    assign hazard_events = '0;
`endif

endmodule
